// File: rtl/ncl_pkg.sv
// Shared dual-rail (NCL) definitions: rail codes, opcode/state enums and
// single-bit rail encode/decode helpers.
package ncl_pkg;
  localparam logic [1:0] NULL = 2'b00;
  localparam logic [1:0] D0   = 2'b01;
  localparam logic [1:0] D1   = 2'b10;

  typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, AND = 2'd2, XOR = 2'd3} opcode_e;
  typedef enum logic [1:0] {S_NULL = 2'd0, S_DATA = 2'd1, S_ERR = 2'd2} state_e;

  function automatic logic [1:0] dr_enc(input logic v);
    return v ? D1 : D0;
  endfunction

  // Only meaningful for a DATA pair; rail1 carries the logical value.
  function automatic logic dr_dec(input logic [1:0] p);
    return p[1];
  endfunction
endpackage

// File: rtl/ncl_completion.sv
// Completion detector over N dual-rail pairs: full DATA, full NULL, or any
// illegal 11 pair.
module ncl_completion #(
  parameter int N = 8
) (
  input  logic [2*N-1:0] w,
  output logic           data_ok,
  output logic           null_ok,
  output logic           ill
);
  logic [N-1:0] pair_dat, pair_ill;

  for (genvar i = 0; i < N; i++) begin : g_pair
    assign pair_dat[i] = ^w[2*i +: 2];
    assign pair_ill[i] = &w[2*i +: 2];
  end

  assign data_ok = &pair_dat;
  assign null_ok = ~|w;
  assign ill     = |pair_ill;
endmodule

// File: rtl/estagio_ula_dr.sv
// Clocked dual-rail ALU stage: four-phase ack handshake, registered DATA
// result with flags, sticky illegal-encoding trap and token counter.
module estagio_ula_dr
  import ncl_pkg::*;
#(
  parameter int W    = 8,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*W-1:0]  a,
  input  logic [2*W-1:0]  b,
  input  logic [3:0]      opr,
  input  logic            ack_in,
  output logic [2*W-1:0]  soma,
  output logic [1:0]      of,
  output logic [1:0]      neg,
  output logic [1:0]      zero,
  output logic [1:0]      cy,
  output logic            ack_out,
  output logic            err,
  output logic [CNTW-1:0] tok_cnt
);
  logic data_ok, null_ok, ill;

  ncl_completion #(.N(2*W+2)) u_cmp (
    .w       ({opr, b, a}),
    .data_ok (data_ok),
    .null_ok (null_ok),
    .ill     (ill)
  );

  logic [W-1:0] a_l, b_l;
  for (genvar i = 0; i < W; i++) begin : g_dec
    assign a_l[i] = dr_dec(a[2*i +: 2]);
    assign b_l[i] = dr_dec(b[2*i +: 2]);
  end

  opcode_e op;
  assign op = opcode_e'({dr_dec(opr[3:2]), dr_dec(opr[1:0])});

  // SUB reuses the adder as a + ~b + 1, so cy reads as "no borrow".
  logic         is_sub;
  logic [W-1:0] b_eff, res;
  logic [W:0]   sum;
  logic         ov, c;

  always_comb begin
    is_sub = (op == SUB);
    b_eff  = is_sub ? ~b_l : b_l;
    sum    = {1'b0, a_l} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};
    res    = sum[W-1:0];
    ov     = (a_l[W-1] == b_eff[W-1]) && (sum[W-1] != a_l[W-1]);
    c      = sum[W];
    case (op)
      AND: begin res = a_l & b_l; ov = 1'b0; c = 1'b0; end
      XOR: begin res = a_l ^ b_l; ov = 1'b0; c = 1'b0; end
      default: ;
    endcase
  end

  state_e state, nxt;
  logic   capture;

  assign capture = (state == S_NULL) && !ill && data_ok && ack_in;

  always_ff @(posedge clk) begin
    if (rst) state <= S_NULL;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_NULL: if (ill) nxt = S_ERR;
              else if (data_ok && ack_in) nxt = S_DATA;
      S_DATA: if (ill) nxt = S_ERR;
              else if (null_ok && !ack_in) nxt = S_NULL;
      S_ERR:  nxt = S_ERR;
      default: nxt = S_ERR;
    endcase
  end

  logic [W-1:0] res_q;
  logic         of_q, cy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      of_q    <= 1'b0;
      cy_q    <= 1'b0;
      tok_cnt <= '0;
    end else if (capture) begin
      res_q   <= res;
      of_q    <= ov;
      cy_q    <= c;
      tok_cnt <= tok_cnt + 1'b1;
    end
  end

  // Rails are only driven in S_DATA; every other state presents NULL.
  always_comb begin
    soma    = '0;
    of      = NULL;
    neg     = NULL;
    zero    = NULL;
    cy      = NULL;
    ack_out = 1'b0;
    err     = 1'b0;
    case (state)
      S_NULL: ack_out = 1'b1;
      S_DATA: begin
        for (int i = 0; i < W; i++) soma[2*i +: 2] = dr_enc(res_q[i]);
        of   = dr_enc(of_q);
        neg  = dr_enc(res_q[W-1]);
        zero = dr_enc(res_q == '0);
        cy   = dr_enc(cy_q);
      end
      S_ERR: err = 1'b1;
      default: err = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_estagio_ula_dr.sv
// Directed scoreboard bench for estagio_ula_dr at W=4, CNTW=2.
module tb_estagio_ula_dr;
  import ncl_pkg::*;

  localparam int W = 4;
  localparam int CNTW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*W-1:0]  a, b;
  logic [3:0]      opr;
  logic            ack_in;
  logic [2*W-1:0]  soma;
  logic [1:0]      of, neg, zero, cy;
  logic            ack_out, err;
  logic [CNTW-1:0] tok_cnt;

  estagio_ula_dr #(.W(W), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .opr(opr), .ack_in(ack_in),
    .soma(soma), .of(of), .neg(neg), .zero(zero), .cy(cy),
    .ack_out(ack_out), .err(err), .tok_cnt(tok_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] soma;
    logic [7:0] flags;
    logic       ack;
    logic       err;
    logic [1:0] tok;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_cnt  = 0;

  function automatic logic [7:0] enc4(input logic [3:0] v);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic exp_t null_x(input int cnt);
    exp_t e;
    e = '0; e.ack = 1'b1; e.tok = 2'(cnt);
    return e;
  endfunction

  function automatic exp_t err_x(input int cnt);
    exp_t e;
    e = '0; e.err = 1'b1; e.tok = 2'(cnt);
    return e;
  endfunction

  function automatic exp_t data_x(input int av, input int bv, input int op, input int cnt);
    exp_t e;
    int r, sa, sb, sr;
    bit o, c;
    logic [3:0] rr;
    sa = (av > 7) ? av - 16 : av;
    sb = (bv > 7) ? bv - 16 : bv;
    o = 0; c = 0;
    case (op)
      0: begin r = av + bv; c = (r > 15); sr = sa + sb; o = (sr > 7) || (sr < -8); end
      1: begin r = av - bv; c = (av >= bv); sr = sa - sb; o = (sr > 7) || (sr < -8); end
      2: r = av & bv;
      default: r = av ^ bv;
    endcase
    rr = 4'(r);
    e.soma  = enc4(rr);
    e.flags = {(o ? 2'b10 : 2'b01), (rr[3] ? 2'b10 : 2'b01),
               ((rr == 4'd0) ? 2'b10 : 2'b01), (c ? 2'b10 : 2'b01)};
    e.ack = 1'b0; e.err = 1'b0; e.tok = 2'(cnt);
    return e;
  endfunction

  task automatic drv(input int av, input int bv, input int op, input bit ack);
    logic [1:0] o2;
    o2 = 2'(op);
    a = enc4(4'(av)); b = enc4(4'(bv));
    opr = {(o2[1] ? 2'b10 : 2'b01), (o2[0] ? 2'b10 : 2'b01)};
    ack_in = ack;
  endtask

  task automatic drv_null(input bit ack);
    a = '0; b = '0; opr = '0; ack_in = ack;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk); #1;
    checks++;
    assert (q.size() > 0) else begin
      errors++; $error("FAIL %s: scoreboard empty, got none want entry", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      checks += 5;
      assert (soma === e.soma) else begin
        errors++; $error("FAIL %s.soma: got %h want %h", tag, soma, e.soma); end
      assert ({of, neg, zero, cy} === e.flags) else begin
        errors++; $error("FAIL %s.flags: got %h want %h", tag, {of, neg, zero, cy}, e.flags); end
      assert (ack_out === e.ack) else begin
        errors++; $error("FAIL %s.ack_out: got %b want %b", tag, ack_out, e.ack); end
      assert (err === e.err) else begin
        errors++; $error("FAIL %s.err: got %b want %b", tag, err, e.err); end
      assert (tok_cnt === e.tok) else begin
        errors++; $error("FAIL %s.tok_cnt: got %0d want %0d", tag, tok_cnt, e.tok); end
    end
  endtask

  task automatic token(input int av, input int bv, input int op, input string tag);
    m_cnt = (m_cnt + 1) % 4;
    drv(av, bv, op, 1'b1); q.push_back(data_x(av, bv, op, m_cnt)); tick(tag);
    drv_null(1'b0);        q.push_back(null_x(m_cnt));              tick({tag, "_null"});
  endtask

  initial begin
    // Reset with random (possibly illegal) inputs
    rst = 1'b1;
    a = 8'($urandom); b = 8'($urandom); opr = 4'($urandom); ack_in = 1'($urandom);
    q.push_back(null_x(0)); tick("rst0");
    a = 8'($urandom); b = 8'($urandom);
    q.push_back(null_x(0)); tick("rst1");
    rst = 1'b0;
    drv_null(1'b1); q.push_back(null_x(0)); tick("idle");

    // ADD with held output while inputs move
    m_cnt = 1;
    drv(5, 3, 0, 1'b1); q.push_back(data_x(5, 3, 0, 1)); tick("add53");
    drv(1, 1, 3, 1'b1); q.push_back(data_x(5, 3, 0, 1)); tick("add_hold");
    drv_null(1'b0);     q.push_back(null_x(1));          tick("add_null");

    token(3, 3, 1, "sub33");
    token(0, 1, 1, "sub01");
    token(12, 10, 2, "and");      // counter wraps 3 -> 0
    token(5, 5, 3, "xor_zero");

    // Back-pressure: DATA ready but downstream wants NULL
    for (int i = 0; i < 5; i++) begin
      drv(7, 1, 0, 1'b0); q.push_back(null_x(m_cnt)); tick("bp_wait");
    end
    m_cnt = (m_cnt + 1) % 4;
    drv(7, 1, 0, 1'b1); q.push_back(data_x(7, 1, 0, m_cnt)); tick("bp_go");
    drv_null(1'b0);     q.push_back(null_x(m_cnt));          tick("bp_null");

    // Partial wavefronts: no capture from S_NULL, no release from S_DATA
    for (int i = 0; i < 3; i++) begin
      drv(0, 3, 0, 1'b1); a = 8'b10_01_00_00;
      q.push_back(null_x(m_cnt)); tick("partial_data");
    end
    m_cnt = (m_cnt + 1) % 4;
    drv(2, 2, 0, 1'b1); q.push_back(data_x(2, 2, 0, m_cnt)); tick("pre_partial");
    drv(2, 2, 0, 1'b0); a = 8'b00_00_01_00;
    q.push_back(data_x(2, 2, 0, m_cnt)); tick("partial_null");
    drv_null(1'b0); q.push_back(null_x(m_cnt)); tick("partial_done");

    // Illegal pair from S_NULL, sticky until reset
    drv(1, 2, 0, 1'b1); b[1:0] = 2'b11;
    q.push_back(err_x(m_cnt)); tick("ill");
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 1) drv(1, 2, 0, 1'b1); else drv_null(1'b0);
      q.push_back(err_x(m_cnt)); tick("ill_sticky");
    end
    rst = 1'b1; drv_null(1'b1); m_cnt = 0;
    q.push_back(null_x(0)); tick("ill_rst");
    rst = 1'b0;

    // Counter wrap 1,2,3,0 then mid-op reset
    token(1, 2, 0, "w1");
    token(9, 9, 0, "w2");   // -7 + -7 overflows, carry out
    token(8, 1, 1, "w3");   // -8 - 1 overflows
    token(15, 0, 2, "w0");
    m_cnt = (m_cnt + 1) % 4;
    drv(6, 2, 1, 1'b1); q.push_back(data_x(6, 2, 1, m_cnt)); tick("pre_rst");
    rst = 1'b1; m_cnt = 0;
    q.push_back(null_x(0)); tick("mid_rst");
    rst = 1'b0; drv_null(1'b1);
    q.push_back(null_x(0)); tick("post_rst");

    // Illegal pair wins over a release request while in S_DATA
    m_cnt = 1;
    drv(4, 4, 0, 1'b1); q.push_back(data_x(4, 4, 0, 1)); tick("pre_ill");
    drv_null(1'b0); opr = 4'b0011;
    q.push_back(err_x(1)); tick("ill_in_data");
    rst = 1'b1; drv_null(1'b1);
    q.push_back(null_x(0)); tick("final_rst");
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
